rr_burst_arb: RTL and testbench

- Round-robin arbiter that shares a single downstream channel among N requesters, at burst granularity.
- Stores the winner as a binary index register.
- Drives the one-hot grant vector from that index through the common `dec` binary-to-one-hot decoder (W=N).
- Holds a grant until the burst ends, then rotates priority. Sits in front of any shared port (memory, bus, FIFO write) needing fair multi-beat access.

---
 rtl/rr_burst_arb_if.sv | 26 ++
 rtl/rr_burst_arb.sv | 184 ++++++++++++++++++
 tb/tb_rr_burst_arb.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rr_burst_arb_if.sv
// Handshake bundle between requesters/downstream port and the burst arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface rr_burst_arb_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req_i;
  logic [N-1:0]     last_i;
  logic             rdy_i;
  logic             gnt_vld_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic [N-1:0]     gnt_o;
  logic             beat_o;
  logic             preempt_o;

  modport slave (
    input  req_i, last_i, rdy_i,
    output gnt_vld_o, gnt_idx_o, gnt_o, beat_o, preempt_o
  );

  modport master (
    output req_i, last_i, rdy_i,
    input  gnt_vld_o, gnt_idx_o, gnt_o, beat_o, preempt_o
  );
endinterface

// File: rtl/rr_burst_arb.sv
// Burst-granular round-robin arbiter: holds one requester's grant until its
// burst ends (last beat, abort or MAX_BEATS preemption), then rotates priority.

// Binary-to-one-hot decoder; codes >= W decode to all zeros.
module dec #(
  parameter int W = 4
) (
  input  logic [$clog2(W)-1:0] bin,
  output logic [W-1:0]         oh
);
  localparam int BW = $clog2(W);

  // One output bit per legal code.
  always_comb begin
    oh = '0;
    for (int i = 0; i < W; i++) begin
      oh[i] = (bin == BW'(i));
    end
  end
endmodule

// Protocol and invariant checks for the arbiter.
module rr_burst_arb_chk #(
  parameter int N = 4
) (
  input logic         clk,
  input logic         arst_n,
  input logic         vld,
  input logic [N-1:0] req,
  input logic [N-1:0] gnt
);
  a_req_known: assert property (@(posedge clk) disable iff (!arst_n)
    !vld |-> !$isunknown(req));

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!arst_n)
    $onehot0(gnt));
endmodule

module rr_burst_arb #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 16
) (
  input logic           clk,
  input logic           arst_n,
  rr_burst_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;

  logic             vld_s;
  logic             beat_s;
  logic             own_req_s;
  logic             own_last_s;
  logic             abort_s;
  logic             normal_s;
  logic             force_s;
  logic             burst_end_s;
  logic [IDX_W-1:0] nxt_ptr_s;
  logic [IDX_W:0]   idle_pick_s;
  logic [IDX_W:0]   busy_pick_s;
  logic [N-1:0]     dec_s;

  // Round-robin scan from start, optionally skipping one index; returns {found, index}.
  function automatic logic [IDX_W:0] pick(
    input logic [N-1:0]     req,
    input logic [IDX_W-1:0] start,
    input logic             excl_en,
    input logic [IDX_W-1:0] excl
  );
    logic             found;
    logic             take;
    logic [IDX_W-1:0] win;
    int               c;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      c     = int'(start) + k;
      c     = (c >= N) ? c - N : c;
      take  = !found && req[c] && !(excl_en && (IDX_W'(c) == excl));
      win   = take ? IDX_W'(c) : win;
      found = found | take;
    end
    return {found, win};
  endfunction

  assign vld_s       = (state_q == BUSY);
  assign beat_s      = vld_s & bus.rdy_i;
  assign own_req_s   = bus.req_i[idx_q];
  assign own_last_s  = bus.last_i[idx_q];
  // Abort dominates: a dropped request ends the burst even if last/rdy are high.
  assign abort_s     = vld_s & !own_req_s;
  assign normal_s    = beat_s & own_last_s & !abort_s;
  assign force_s     = beat_s & (cnt_q == CNT_LAST) & !own_last_s & !abort_s;
  assign burst_end_s = abort_s | normal_s | force_s;
  assign nxt_ptr_s   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
  assign idle_pick_s = pick(bus.req_i, ptr_q, 1'b0, '0);
  assign busy_pick_s = pick(bus.req_i, nxt_ptr_s, 1'b1, idx_q);

  // Next-state: grant acquisition, hold, burst end with back-to-back handover.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (idle_pick_s[IDX_W]) begin
          state_d = BUSY;
          idx_d   = idle_pick_s[IDX_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (burst_end_s) begin
          ptr_d     = nxt_ptr_s;
          cnt_d     = '0;
          preempt_d = force_s;
          if (busy_pick_s[IDX_W]) begin
            state_d = BUSY;
            idx_d   = busy_pick_s[IDX_W-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (beat_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  dec #(.W(N)) u_dec (
    .bin (idx_q),
    .oh  (dec_s)
  );

  assign bus.gnt_vld_o = vld_s;
  assign bus.gnt_idx_o = idx_q;
  assign bus.gnt_o     = dec_s & {N{vld_s}};
  assign bus.beat_o    = beat_s;
  assign bus.preempt_o = preempt_q;

  rr_burst_arb_chk #(.N(N)) u_chk (
    .clk    (clk),
    .arst_n (arst_n),
    .vld    (vld_s),
    .req    (bus.req_i),
    .gnt    (bus.gnt_o)
  );
endmodule

// File: tb/tb_rr_burst_arb.sv
// Directed-vector bench: N=4/MAX_BEATS=4 and N=3/MAX_BEATS=16 arbiters,
// table of per-cycle inputs and hand-computed outputs plus reset sequences.
module tb_rr_burst_arb;
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  rr_burst_arb_if #(.N(4)) bus4();
  rr_burst_arb_if #(.N(3)) bus3();

  rr_burst_arb #(.N(4), .MAX_BEATS(4)) u4 (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus4.slave)
  );

  rr_burst_arb #(.N(3), .MAX_BEATS(16)) u3 (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus3.slave)
  );

  typedef struct {
    bit         sel;   // 0: N=4 instance, 1: N=3 instance
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic       vld;
    logic [1:0] idx;
    logic       beat;
    logic       pre;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(bit sel, logic [3:0] req, logic [3:0] last, logic rdy,
                              logic vld, logic [1:0] idx, logic beat, logic pre);
    vec_t v;
    v.sel = sel; v.req = req; v.last = last; v.rdy = rdy;
    v.vld = vld; v.idx = idx; v.beat = beat; v.pre = pre;
    vecs.push_back(v);
  endfunction

  task automatic drive(bit sel, logic [3:0] req, logic [3:0] last, logic rdy);
    if (sel == 1'b0) begin
      bus4.req_i = req; bus4.last_i = last; bus4.rdy_i = rdy;
      bus3.req_i = 3'b000; bus3.last_i = 3'b000; bus3.rdy_i = 1'b0;
    end else begin
      bus3.req_i = req[2:0]; bus3.last_i = last[2:0]; bus3.rdy_i = rdy;
      bus4.req_i = 4'b0000; bus4.last_i = 4'b0000; bus4.rdy_i = 1'b0;
    end
  endtask

  task automatic check(string name, bit sel, logic e_vld, logic [1:0] e_idx,
                       logic e_beat, logic e_pre);
    logic       a_vld, a_beat, a_pre;
    logic [1:0] a_idx;
    logic [3:0] a_gnt, e_gnt;
    bit         ok;
    if (sel == 1'b0) begin
      a_vld = bus4.gnt_vld_o; a_idx = bus4.gnt_idx_o; a_gnt = bus4.gnt_o;
      a_beat = bus4.beat_o; a_pre = bus4.preempt_o;
    end else begin
      a_vld = bus3.gnt_vld_o; a_idx = bus3.gnt_idx_o; a_gnt = {1'b0, bus3.gnt_o};
      a_beat = bus3.beat_o; a_pre = bus3.preempt_o;
    end
    e_gnt = e_vld ? (4'b0001 << e_idx) : 4'b0000;
    ok = (a_vld === e_vld) && (a_gnt === e_gnt) && (a_beat === e_beat) &&
         (a_pre === e_pre) && (!e_vld || (a_idx === e_idx));
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got vld=%0b idx=%0d gnt=%b beat=%0b pre=%0b, want vld=%0b idx=%0d gnt=%b beat=%0b pre=%0b",
               name, a_vld, a_idx, a_gnt, a_beat, a_pre, e_vld, e_idx, e_gnt, e_beat, e_pre);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    drive(1'b0, 4'b1111, 4'b0000, 1'b1);

    // N=4: reset release, then 2-beat bursts from everybody -> 0,1,2,3,0
    add(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    add(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    add(0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    // everybody drops: abort of 1, go idle (ptr=2)
    add(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    // requester 2 alone, 3 beats with rdy 1,0,1,0,1
    add(0, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    add(0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    add(0, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    add(0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    add(0, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    add(0, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    // sole requester re-requests: one-cycle drop, then re-grant
    add(0, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    add(0, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    add(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    // ptr=3: with 0 and 3 requesting, 3 wins
    add(0, 4'b1001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    add(0, 4'b1010, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    // requester 1 runs 4 beats without last -> preempt, 3 takes over, then 1 again
    add(0, 4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b1010, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
    add(0, 4'b1010, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    // last on the MAX_BEATS-th beat: normal end, no preempt pulse
    add(0, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    add(0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    // requester 0 aborts with rdy=0, grant passes to 1 with no beat
    add(0, 4'b0011, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    add(0, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    add(0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    // last from non-granted requesters is ignored
    add(0, 4'b0010, 4'b1101, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    // last together with dropped request: abort, idle next
    add(0, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    // N=3: 2 finishes, ptr wraps, 0 then 1
    add(1, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    add(1, 4'b0111, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    add(1, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    add(1, 4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    add(1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    add(1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // outputs stay zero while reset is held with all requests high
    tick();
    check("rst_hold_n4", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("rst_hold_n3", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    check("rst_hold2_n4", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    arst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].req, vecs[i].last, vecs[i].rdy);
      #1;
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].vld, vecs[i].idx,
            vecs[i].beat, vecs[i].pre);
      tick();
    end

    // reset mid-burst clears immediately; first grant afterwards scans from 0
    drive(1'b0, 4'b0100, 4'b0000, 1'b0);
    #1;
    check("mr_idle", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    check("mr_grant", 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    bus4.rdy_i = 1'b1;
    arst_n = 1'b0;
    #1;
    check("mr_reset", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    arst_n = 1'b1;
    drive(1'b0, 4'b1010, 4'b0000, 1'b0);
    #1;
    check("mr_release", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    check("mr_ptr0", 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
